// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver backing the memory-mapped UART registers.
//   udrr (cell 25) holds the last good byte; usr (cell 24) = {ERR, RXC}, sticky.
//   rd_ack (CPU read of cell 25) clears both status bits.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit after the data.
module uart_rx_unit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] udrr,
    output logic [1:0] usr,
    output logic       rx_done
);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_t;
`endif

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_err_q, par_err_d;
    logic [7:0]       udrr_q, udrr_d;
    logic             rxc_q, rxc_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic bit_end, half_end;
    assign bit_end  = (cnt_q == BIT_END);
    assign half_end = (cnt_q == HALF_END);

    // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
    // NOTE: clocked blocks use <= so every flop samples pre-edge values; = here would collapse the two stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State register together with the datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            udrr_q    <= '0;
            rxc_q     <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            udrr_q    <= udrr_d;
            rxc_q     <= rxc_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: frame sequencing driven by the synchronized line.
    // NOTE: a default assignment before the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s_q) state_d = S_START;
            S_START:     if (half_end) state_d = rx_s_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:      if (bit_end && bit_q == 3'd7) state_d = S_PARITY;
            S_PARITY:    if (bit_end) state_d = S_STOP;
`else
            S_DATA:      if (bit_end && bit_q == 3'd7) state_d = S_STOP;
`endif
            S_STOP:      if (bit_end) state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: bit timing, shifting, and status register updates.
    always_comb begin
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        udrr_d    = udrr_q;
        rxc_d     = rxc_q;
        err_d     = err_q;
        done_d    = 1'b0;

        // A CPU read clears status; a completing frame below may set bits again.
        if (rd_ack) begin
            rxc_d = 1'b0;
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_d     = '0;
                par_err_d = 1'b0;
            end
            S_START: begin
                cnt_d = half_end ? '0 : cnt_q + CNT_W'(1);
                bit_d = '0;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    par_err_d = ^{shift_q, rx_s_q};
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (rx_s_q && !par_err_q) begin
                        if (!rxc_q || rd_ack) begin
                            udrr_d = shift_q;
                            rxc_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign udrr    = udrr_q;
    assign usr     = {err_q, rxc_q};
    assign rx_done = done_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Testbench for uart_rx_unit: directed vector table, hand-written corner sequences,
// and randomized frames checked against a register-level behavioural model.
module tb_uart_rx_unit;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_ack;
    logic [7:0] udrr;
    logic [1:0] usr;
    logic       rx_done;

    always #5 clk = ~clk;

    uart_rx_unit #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rd_ack  (rd_ack),
        .udrr    (udrr),
        .usr     (usr),
        .rx_done (rx_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // Behavioural model of the two CPU-visible registers.
    logic [7:0] m_udrr;
    logic       m_rxc;
    logic       m_err;

    typedef struct {
        logic       ack_before;
        logic [7:0] data;
        logic       stop_b;
        logic [7:0] exp_udrr;
        logic [1:0] exp_usr;
    } vec_t;

    vec_t vecs [5];

    // Count completed frames; the pulse is one cycle wide so one sample per pulse.
    always @(negedge clk) if (rx_done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_udrr = 8'h00;
        m_rxc  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_ack();
        m_rxc = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        if (stop_ok && par_ok) begin
            if (!m_rxc) begin
                m_udrr = d;
                m_rxc  = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_data_bits(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    // Full frame plus two idle bit times; updates the model.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_data_bits(d);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
        model_frame(d, stop_b, par_b == ^d);
`else
        model_frame(d, stop_b, 1'b1);
`endif
        drive_bit(stop_b);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        model_ack();
    endtask

    initial begin
        int d0;
        logic [7:0] rd;
        logic rs, ra, rp;

        vecs[0] = '{1'b1, 8'h3C, 1'b1, 8'h3C, 2'b01};
        vecs[1] = '{1'b1, 8'h11, 1'b1, 8'h11, 2'b01};
        vecs[2] = '{1'b0, 8'h22, 1'b1, 8'h11, 2'b11};
        vecs[3] = '{1'b1, 8'h55, 1'b0, 8'h11, 2'b10};
        vecs[4] = '{1'b0, 8'h77, 1'b1, 8'h77, 2'b11};

        rst    = 1'b1;
        rx     = 1'b1;
        rd_ack = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("reset udrr", 32'(udrr), 32'h00);
        check("reset usr", 32'(usr), 32'h0);
        check("reset rx_done", 32'(rx_done), 32'h0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // First frame: nothing visible before the stop-bit sample.
        d0 = done_cnt;
        send_data_bits(8'hA5);
`ifdef UART_RX_PARITY_EN
        drive_bit(^8'hA5);
`endif
        check("A5 usr before stop", 32'(usr), 32'h0);
        check("A5 done before stop", 32'(done_cnt - d0), 32'd0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        model_frame(8'hA5, 1'b1, 1'b1);
        check("A5 udrr", 32'(udrr), 32'hA5);
        check("A5 usr", 32'(usr), 32'h1);
        check("A5 done count", 32'(done_cnt - d0), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].ack_before) begin
                pulse_ack();
                check($sformatf("vec%0d usr after ack", i), 32'(usr), 32'h0);
            end
            d0 = done_cnt;
            send_frame(vecs[i].data, vecs[i].stop_b, ^vecs[i].data);
            check($sformatf("vec%0d udrr", i), 32'(udrr), 32'(vecs[i].exp_udrr));
            check($sformatf("vec%0d usr", i), 32'(usr), 32'(vecs[i].exp_usr));
            check($sformatf("vec%0d done", i), 32'(done_cnt - d0), 32'd1);
        end

        // Break: bad stop bit then the line held low for 40 bit times.
        pulse_ack();
        check("break pre-ack usr", 32'(usr), 32'h0);
        d0 = done_cnt;
        send_data_bits(8'h55);
`ifdef UART_RX_PARITY_EN
        drive_bit(^8'h55);
`endif
        for (int i = 0; i < 41; i++) drive_bit(1'b0);
        model_frame(8'h55, 1'b0, 1'b1);
        check("break usr", 32'(usr), 32'h2);
        check("break single done", 32'(done_cnt - d0), 32'd1);
        check("break udrr kept", 32'(udrr), 32'h77);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h66, 1'b1, ^8'h66);
        check("after break udrr", 32'(udrr), 32'h66);
        check("after break usr", 32'(usr), 32'h3);
        pulse_ack();
        check("after break ack usr", 32'(usr), 32'h0);

        // Short low glitch on an idle line must be rejected.
        d0 = done_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch done", 32'(done_cnt - d0), 32'd0);
        check("glitch usr", 32'(usr), 32'h0);

        // Reset in the middle of a frame (during bit 4).
        send_frame(8'h5A, 1'b1, ^8'h5A);
        check("pre-reset udrr", 32'(udrr), 32'h5A);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(i % 2));
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midframe rst udrr", 32'(udrr), 32'h00);
        check("midframe rst usr", 32'(usr), 32'h0);
        check("midframe rst rx_done", 32'(rx_done), 32'h0);
        repeat (12 * CPB) @(negedge clk);
        send_frame(8'h81, 1'b1, ^8'h81);
        check("0x81 udrr", 32'(udrr), 32'h81);
        check("0x81 usr", 32'(usr), 32'h1);

`ifdef UART_RX_PARITY_EN
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b1);
        check("par good udrr", 32'(udrr), 32'h07);
        check("par good usr", 32'(usr), 32'h1);
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b0);
        check("par bad usr err", 32'(usr[1]), 32'h1);
        check("par bad udrr", 32'(udrr), 32'h07);
        pulse_ack();
        d0 = done_cnt;
        send_frame(8'h0F, 1'b1, 1'b1);
        check("par bad 0F udrr kept", 32'(udrr), 32'h07);
        check("par bad 0F usr", 32'(usr), 32'h2);
        check("par bad 0F done", 32'(done_cnt - d0), 32'd1);
`endif

        // Randomized frames against the register-level model.
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom_range(0, 255));
            ra = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 7) != 0);
            rp = ^rd;
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 5) == 0) rp = ~rp;
`endif
            if (ra) pulse_ack();
            d0 = done_cnt;
            send_frame(rd, rs, rp);
            check($sformatf("rand%0d udrr", i), 32'(udrr), 32'(m_udrr));
            check($sformatf("rand%0d usr", i), 32'(usr), 32'({m_err, m_rxc}));
            check($sformatf("rand%0d done", i), 32'(done_cnt - d0), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
